reg_file_sb: RTL and testbench



---
 rtl/reg_file_sb_pkg.sv | 19 +
 rtl/reg_file_sb_rf_word.sv | 30 +++
 rtl/reg_file_sb.sv | 92 +++++++++
 tb/tb_reg_file_sb.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pa_rf_pkg
// Description : Shared sizes, the hardwired-zero index and register typedefs.
// Revision    : 1.0 - initial release
// ============================================================================
package pa_rf_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage
`default_nettype wire

// File: rtl/reg_file_sb_rf_word.sv
`default_nettype none
// ============================================================================
// Module      : rf_word
// Description : One register-file word with write enable and async clear.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_word #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_we) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb
// Description : 32-entry register file, two bypassed read ports, busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
import pa_rf_pkg::*;

module reg_file_sb #(
    parameter int DATA_W   = pa_rf_pkg::DATA_W,
    parameter int NUM_REGS = pa_rf_pkg::NUM_REGS,
    parameter int ADDR_W   = pa_rf_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic              rs1_use,
    input  logic              rs2_use,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              stall,
    output logic              issued
);

    logic [DATA_W-1:0]   w_q [NUM_REGS];
    logic [NUM_REGS-1:1] w_we;
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic                w_wr_hit;
    logic                w_rs1_busy;
    logic                w_rs2_busy;

    assign w_wr_hit = wr_en && (wr_addr != ADDR_W'(ZERO_REG));

    always_comb begin
        w_we = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_we[i] = w_wr_hit && (wr_addr == ADDR_W'(i));
        end
    end

    assign w_q[0] = '0;

    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_word
        rf_word #(.DATA_W(DATA_W)) u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .i_we  (w_we[gi]),
            .i_d   (wr_data),
            .o_q   (w_q[gi])
        );
    end

    // Write-first bypass: a same-cycle writeback is visible on the read ports.
    assign rs1_data = (w_wr_hit && (wr_addr == rs1_addr)) ? wr_data : w_q[rs1_addr];
    assign rs2_data = (w_wr_hit && (wr_addr == rs2_addr)) ? wr_data : w_q[rs2_addr];

    assign w_rs1_busy = r_busy[rs1_addr] && !(wr_en && (wr_addr == rs1_addr));
    assign w_rs2_busy = r_busy[rs2_addr] && !(wr_en && (wr_addr == rs2_addr));

    assign stall  = (rs1_use && w_rs1_busy) || (rs2_use && w_rs2_busy);
    assign issued = iss_en && !stall;

    // A new producer claiming a register wins over a retiring writeback.
    always_comb begin
        w_busy_nxt = r_busy;
        w_busy_nxt[0] = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (issued && (iss_rd == ADDR_W'(i))) begin
                w_busy_nxt[i] = 1'b1;
            end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_sb
// Description : Directed vector table plus reset and x0 sequences for reg_file_sb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr, iss_rd;
    logic        rs1_use, rs2_use, wr_en, iss_en;
    logic [31:0] wr_data;
    logic [31:0] rs1_data, rs2_data;
    logic        stall, issued;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_use  (rs1_use),
        .rs2_use  (rs2_use),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .stall    (stall),
        .issued   (issued)
    );

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        u1, u2;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ird;
        logic [31:0] e1, e2;
        logic        es, ei;
    } vec_t;

    vec_t tv [17];

    function automatic vec_t mk(logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                logic we, logic [4:0] wa, logic [31:0] wd,
                                logic ie, logic [4:0] ird,
                                logic [31:0] e1, logic [31:0] e2, logic es, logic ei);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ird = ird;
        v.e1 = e1; v.e2 = e2; v.es = es; v.ei = ei;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic u1,
                         input logic u2, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic ie, input logic [4:0] ird);
        rs1_addr = a1; rs2_addr = a2; rs1_use = u1; rs2_use = u2;
        wr_en = we; wr_addr = wa; wr_data = wd; iss_en = ie; iss_rd = ird;
    endtask

    initial begin
        //        rs1 rs2 u1 u2 we wa  wd            ie ird  e1            e2            es ei
        tv[0]  = mk(7,  0, 0, 0, 1, 7, 32'hA5A5A5A5, 0, 0,  32'hA5A5A5A5, 32'h0,        0, 0);
        tv[1]  = mk(7,  7, 0, 0, 0, 0, 32'h0,        0, 0,  32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0);
        tv[2]  = mk(3,  0, 0, 0, 1, 3, 32'h11,       0, 0,  32'h11,        32'h0,        0, 0);
        tv[3]  = mk(7,  3, 0, 0, 1, 3, 32'h55,       0, 0,  32'hA5A5A5A5, 32'h55,       0, 0);
        tv[4]  = mk(3,  7, 0, 0, 0, 0, 32'h0,        0, 0,  32'h55,        32'hA5A5A5A5, 0, 0);
        tv[5]  = mk(9,  0, 0, 0, 0, 0, 32'h0,        1, 9,  32'h0,         32'h0,        0, 1);
        tv[6]  = mk(9,  0, 1, 0, 0, 0, 32'h0,        1, 12, 32'h0,         32'h0,        1, 0);
        tv[7]  = mk(9,  0, 1, 0, 1, 9, 32'h77,       1, 12, 32'h77,        32'h0,        0, 1);
        tv[8]  = mk(9, 12, 1, 1, 0, 0, 32'h0,        0, 0,  32'h77,        32'h0,        1, 0);
        tv[9]  = mk(9, 12, 1, 0, 0, 0, 32'h0,        1, 4,  32'h77,        32'h0,        0, 1);
        tv[10] = mk(4,  0, 1, 0, 1, 4, 32'h44,       1, 4,  32'h44,        32'h0,        0, 1);
        tv[11] = mk(4,  0, 1, 0, 0, 0, 32'h0,        1, 5,  32'h44,        32'h0,        1, 0);
        tv[12] = mk(4,  0, 0, 0, 1, 4, 32'h45,       1, 10, 32'h45,        32'h0,        0, 1);
        tv[13] = mk(4, 10, 1, 0, 0, 0, 32'h0,        1, 11, 32'h45,        32'h0,        0, 1);
        tv[14] = mk(0, 10, 0, 0, 0, 0, 32'h0,        0, 0,  32'h0,         32'h0,        0, 0);
        tv[15] = mk(0, 10, 0, 1, 0, 0, 32'h0,        1, 13, 32'h0,         32'h0,        1, 0);
        tv[16] = mk(12, 0, 1, 0, 0, 0, 32'h0,        1, 12, 32'h0,         32'h0,        1, 0);

        drive(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        rst_n = 1'b0;
        #2;
        chk("reset rs1_data", rs1_data, 32'h0);
        chk("reset rs2_data", rs2_data, 32'h0);
        chk("reset stall", {31'b0, stall}, 32'h0);
        chk("reset issued", {31'b0, issued}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(tv[i].rs1, tv[i].rs2, tv[i].u1, tv[i].u2, tv[i].we, tv[i].wa,
                  tv[i].wd, tv[i].ie, tv[i].ird);
            #1;
            chk($sformatf("v%0d rs1_data", i), rs1_data, tv[i].e1);
            chk($sformatf("v%0d rs2_data", i), rs2_data, tv[i].e2);
            chk($sformatf("v%0d stall", i), {31'b0, stall}, {31'b0, tv[i].es});
            chk($sformatf("v%0d issued", i), {31'b0, issued}, {31'b0, tv[i].ei});
        end

        // Mid-run asynchronous reset after reg5 holds data and reg12 is busy.
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        @(negedge clk);
        drive(5, 12, 0, 1, 0, 0, 32'h0, 0, 0);
        #1;
        chk("pre-reset reg5", rs1_data, 32'hDEADBEEF);
        chk("pre-reset stall", {31'b0, stall}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async reset reg5", rs1_data, 32'h0);
        chk("async reset stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(7, 3, 1, 1, 0, 0, 32'h0, 0, 0);
        #1;
        chk("post-reset reg7", rs1_data, 32'h0);
        chk("post-reset reg3", rs2_data, 32'h0);

        // Register 0: writes ignored, no bypass, never busy.
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 32'h1234, 1, 0);
        #1;
        chk("x0 no bypass", rs1_data, 32'h0);
        chk("x0 issue", {31'b0, issued}, 32'h1);
        @(negedge clk);
        drive(0, 0, 1, 1, 0, 0, 32'h0, 0, 0);
        #1;
        chk("x0 read after write", rs1_data, 32'h0);
        chk("x0 never busy", {31'b0, stall}, 32'h0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
